seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of NDIG common-anode 7-segment digits that share one segment bus. It holds a double-buffered hex value and steps through the digits one at a time, driving the active-low digit enables. Each digit is decoded to active-low segments, and a guard blanking interval between digits suppresses ghosting. Optional leading-zero blanking is supported. The block sits between a register/bus master that writes values and the board-level display pins.

---
 rtl/seg7_scan_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Purpose : time-multiplexed scan of NDIG common-anode 7-seg digits with guard blanking,
//           double-buffered hex value and optional leading-zero blanking.
// Latency : all outputs registered; a loaded value appears from digit 0 of the next frame.
// Backpressure: none; load is always accepted, the last load before a frame boundary wins.
// Ports: clk/rst (sync, active-high); en scan enable; load/value/dp_in write the pending
//        buffer; lz_blank enables leading-zero blanking; seg/dp/an active-low display pins;
//        digit_idx current slot index; frame_done one-cycle pulse at the start of each frame.
module seg7_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2,
  parameter int CW       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              lz_blank,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic [2:0]        digit_idx,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [CW-1:0] PLAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GLAST   = (GUARD > 0) ? CW'(GUARD - 1) : '0;
  localparam logic [2:0]    LASTDIG = 3'(NDIG - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [2:0]        idx, idx_nxt;
  logic              boundary, entry;

  logic [4*NDIG-1:0] pend, disp, disp_nxt;
  logic [NDIG-1:0]   pend_dp, disp_dp, disp_dp_nxt;
  logic              pend_vld, pend_vld_nxt;

  logic [6:0]        seg_nxt;
  logic              dp_nxt;
  logic [NDIG-1:0]   an_nxt;
  logic [2:0]        digit_idx_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Next-state: slot sequencing and the frame-boundary / scan-entry events.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    boundary  = 1'b0;
    entry     = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          entry     = 1'b1;
          idx_nxt   = 3'd0;
          cnt_nxt   = '0;
          state_nxt = (GUARD > 0) ? BLANK : SHOW;
        end
      end
      BLANK: begin
        if (cnt == GLAST) begin
          cnt_nxt   = '0;
          state_nxt = SHOW;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SHOW: begin
        if (cnt == PLAST) begin
          cnt_nxt   = '0;
          state_nxt = (GUARD > 0) ? BLANK : SHOW;
          if (idx == LASTDIG) begin
            idx_nxt  = 3'd0;
            boundary = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Dropping en aborts the frame outright: no boundary, pending stays put.
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = 3'd0;
      cnt_nxt   = '0;
      boundary  = 1'b0;
      entry     = 1'b0;
    end
  end

  // Display buffer only updates at a frame boundary or on scan entry, so a frame never tears.
  // A load coinciding with the boundary goes straight to the display.
  always_comb begin
    disp_nxt     = disp;
    disp_dp_nxt  = disp_dp;
    pend_vld_nxt = pend_vld | load;
    if (boundary) begin
      pend_vld_nxt = 1'b0;
      if (load) begin
        disp_nxt    = value;
        disp_dp_nxt = dp_in;
      end else if (pend_vld) begin
        disp_nxt    = pend;
        disp_dp_nxt = pend_dp;
      end
    end else if (entry) begin
      pend_vld_nxt = load;
      if (pend_vld) begin
        disp_nxt    = pend;
        disp_dp_nxt = pend_dp;
      end
    end
  end

  // Output decode from next-cycle state so the registered pins line up with the FSM state.
  always_comb begin
    logic [3:0]      nib;
    logic            dpb;
    logic            zrun;
    logic [NDIG-1:0] lzm;
    nib           = 4'h0;
    dpb           = 1'b0;
    zrun          = 1'b1;
    lzm           = '0;
    seg_nxt       = 7'h7F;
    dp_nxt        = 1'b1;
    an_nxt        = '1;
    digit_idx_nxt = (state_nxt == IDLE) ? 3'd0 : idx_nxt;
    // lzm[k] = nibbles k..NDIG-1 are all zero
    for (int k = NDIG - 1; k >= 0; k--) begin
      zrun   = zrun & (disp_nxt[4*k +: 4] == 4'h0);
      lzm[k] = zrun;
    end
    for (int k = 0; k < NDIG; k++) begin
      if (idx_nxt == 3'(k)) begin
        nib = disp_nxt[4*k +: 4];
        dpb = disp_dp_nxt[k];
        if (state_nxt == SHOW) begin
          an_nxt[k] = 1'b0;
          dp_nxt    = ~dpb;
          // Blanked digits keep their anode slot so brightness/timing stays uniform.
          if (lz_blank && (k > 0) && lzm[k]) seg_nxt = 7'h7F;
          else                               seg_nxt = hex7(nib);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 3'd0;
      pend       <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      disp       <= '0;
      disp_dp    <= '0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      digit_idx  <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      if (load) begin
        pend    <= value;
        pend_dp <= dp_in;
      end
      pend_vld   <= pend_vld_nxt;
      disp       <= disp_nxt;
      disp_dp    <= disp_dp_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      an         <= an_nxt;
      digit_idx  <= digit_idx_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: NDIG=4, PRESCALE=4, GUARD=1 -> 20-cycle frame
  logic        rst = 1'b1, en = 1'b0, load = 1'b0, lz_blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp, frame_done;
  logic [3:0]  an;
  logic [2:0]  digit_idx;

  // Second instance: GUARD=0, PRESCALE=1 -> digit changes every cycle
  logic        r0 = 1'b1, en0 = 1'b0, load0 = 1'b0, lz0 = 1'b0;
  logic [15:0] value0 = '0;
  logic [3:0]  dp0_in = '0;
  logic [6:0]  seg0;
  logic        dp0, fd0;
  logic [3:0]  an0;
  logic [2:0]  idx0;

  seg7_scan_ctrl #(.NDIG(4), .PRESCALE(4), .GUARD(1), .CW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx),
    .frame_done(frame_done));

  seg7_scan_ctrl #(.NDIG(4), .PRESCALE(1), .GUARD(0), .CW(4)) dut0 (
    .clk(clk), .rst(r0), .en(en0), .load(load0), .value(value0), .dp_in(dp0_in),
    .lz_blank(lz0), .seg(seg0), .dp(dp0), .an(an0), .digit_idx(idx0),
    .frame_done(fd0));

  int checks = 0;
  int errors = 0;

  // {frame_done, digit_idx, an, seg, dp} per cycle of one frame
  logic [15:0] cap [20];
  logic        cap_fd_next;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S8 = 7'b0000000, SA = 7'b0001000, SB = 7'b0000011,
                         SC = 7'b1000110, SD = 7'b0100001, SOFF = 7'h7F;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Records one frame starting at a frame_done cycle; optionally loads at cycle load_at.
  task automatic capture_frame(input int load_at, input logic [15:0] v, input logic [3:0] dv);
    for (int i = 0; i < 20; i++) begin
      cap[i] = {frame_done, digit_idx, an, seg, dp};
      if (i == load_at) begin
        load = 1'b1; value = v; dp_in = dv;
      end
      tick();
      load = 1'b0;
    end
    cap_fd_next = frame_done;
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (frame_done === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  // Expected sample for cycle i of a frame: slot d = i/5, position 0 is the guard cycle.
  function automatic logic [15:0] exp_cycle(input int i, input logic [27:0] segs, input logic [3:0] dps);
    int d, pos;
    logic [3:0] a;
    logic [6:0] s;
    logic       p;
    d = i / 5;
    pos = i % 5;
    if (pos == 0) begin
      a = 4'b1111; s = SOFF; p = 1'b1;
    end else begin
      a = ~(4'b0001 << d); s = segs[7*d +: 7]; p = ~dps[d];
    end
    return {(i == 0), 3'(d), a, s, p};
  endfunction

  task automatic test_reset;
    rst = 1'b1; r0 = 1'b1; en = 1'b1; load = 1'b1; value = 16'hFFFF; en0 = 1'b1;
    tick(); tick();
    load = 1'b0; en = 1'b0; en0 = 1'b0;
    checks++;
    if ({an, seg, dp, digit_idx, frame_done} !== {4'b1111, SOFF, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_main: an=%b seg=%b dp=%b idx=%0d fd=%b", an, seg, dp, digit_idx, frame_done);
    end
    checks++;
    if ({an0, seg0, dp0, idx0, fd0} !== {4'b1111, SOFF, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_g0: an=%b seg=%b dp=%b idx=%0d fd=%b", an0, seg0, dp0, idx0, fd0);
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({an, seg, dp} !== {4'b1111, SOFF, 1'b1}) begin
      errors++;
      $display("FAIL idle_dark: an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
    end
  endtask

  task automatic test_basic;
    bit ok;
    logic [15:0] e;
    en = 1'b1;
    tick();
    checks++;
    if ({an, seg, digit_idx} !== {4'b1111, SOFF, 3'd0}) begin
      errors++;
      $display("FAIL entry_blank: an=%b seg=%b idx=%0d want 1111/1111111/0", an, seg, digit_idx);
    end
    tick();
    checks++;
    if ({an, seg, digit_idx} !== {4'b1110, S0, 3'd0}) begin
      errors++;
      $display("FAIL first_digit: an=%b seg=%b idx=%0d want 1110/%b/0", an, seg, digit_idx, S0);
    end
    load = 1'b1; value = 16'h1234; dp_in = 4'b0000;
    tick();
    load = 1'b0;
    wait_fd(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_fd_timeout: frame_done=%b want 1 within 100 cycles", frame_done);
    end
    capture_frame(-1, 16'h0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      e = exp_cycle(i, {S1, S2, S3, S4}, 4'b0000);
      checks++;
      if (cap[i] !== e) begin
        errors++;
        $display("FAIL basic_cycle%0d: got %h want %h", i, cap[i], e);
      end
    end
  endtask

  task automatic test_timing;
    int pulses, bad;
    checks++;
    if (cap_fd_next !== 1'b1) begin
      errors++;
      $display("FAIL frame_period: frame_done=%b at cycle 20 want 1", cap_fd_next);
    end
    capture_frame(-1, 16'h0, 4'h0);
    pulses = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (cap[i][15]) pulses++;
      if ($countones(~cap[i][11:8]) > 1) bad++;
      if (cap[i][11:8] == 4'b1111 && cap[i][7:1] != SOFF) bad++;
    end
    checks++;
    if (pulses != 1 || cap_fd_next !== 1'b1) begin
      errors++;
      $display("FAIL fd_once: pulses=%0d next=%b want 1/1", pulses, cap_fd_next);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL an_onehot: violations=%0d want 0", bad);
    end
  endtask

  task automatic test_tearing;
    logic [15:0] e;
    capture_frame(6, 16'hABCD, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      e = exp_cycle(i, {S1, S2, S3, S4}, 4'b0000);
      checks++;
      if (cap[i] !== e) begin
        errors++;
        $display("FAIL tear_old_cycle%0d: got %h want %h", i, cap[i], e);
      end
    end
    capture_frame(-1, 16'h0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      e = exp_cycle(i, {SA, SB, SC, SD}, 4'b0000);
      checks++;
      if (cap[i] !== e) begin
        errors++;
        $display("FAIL tear_new_cycle%0d: got %h want %h", i, cap[i], e);
      end
    end
  endtask

  task automatic test_lz_blank;
    logic [15:0] e;
    lz_blank = 1'b1;
    capture_frame(0, 16'h0050, 4'b0000);
    capture_frame(0, 16'h0000, 4'b1000);
    for (int i = 0; i < 20; i++) begin
      e = exp_cycle(i, {SOFF, SOFF, S5, S0}, 4'b0000);
      checks++;
      if (cap[i] !== e) begin
        errors++;
        $display("FAIL lz_0050_cycle%0d: got %h want %h", i, cap[i], e);
      end
    end
    capture_frame(-1, 16'h0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      e = exp_cycle(i, {SOFF, SOFF, SOFF, S0}, 4'b1000);
      checks++;
      if (cap[i] !== e) begin
        errors++;
        $display("FAIL lz_zero_cycle%0d: got %h want %h", i, cap[i], e);
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_en_drop;
    for (int i = 0; i < 11; i++) tick();
    checks++;
    if ({an, digit_idx} !== {4'b1011, 3'd2}) begin
      errors++;
      $display("FAIL endrop_pre: an=%b idx=%0d want 1011/2", an, digit_idx);
    end
    en = 1'b0; load = 1'b1; value = 16'h5678; dp_in = 4'b0000;
    tick();
    load = 1'b0;
    checks++;
    if ({an, seg, dp, digit_idx, frame_done} !== {4'b1111, SOFF, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL endrop_dark: an=%b seg=%b dp=%b idx=%0d fd=%b", an, seg, dp, digit_idx, frame_done);
    end
    tick(); tick();
    checks++;
    if ({an, seg, frame_done} !== {4'b1111, SOFF, 1'b0}) begin
      errors++;
      $display("FAIL endrop_stay: an=%b seg=%b fd=%b want 1111/1111111/0", an, seg, frame_done);
    end
    en = 1'b1;
    tick();
    checks++;
    if ({an, seg, digit_idx} !== {4'b1111, SOFF, 3'd0}) begin
      errors++;
      $display("FAIL reen_blank: an=%b seg=%b idx=%0d want 1111/1111111/0", an, seg, digit_idx);
    end
    tick();
    checks++;
    if ({an, seg, dp} !== {4'b1110, S8, 1'b1}) begin
      errors++;
      $display("FAIL reen_pending: an=%b seg=%b dp=%b want 1110/%b/1", an, seg, dp, S8);
    end
  endtask

  task automatic test_guard0_rst;
    logic [3:0] ea [6];
    logic [6:0] es [6];
    logic       ef [6];
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    es = '{S4, S3, S2, S1, S4, S3};
    ef = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    r0 = 1'b1; tick(); r0 = 1'b0;
    load0 = 1'b1; value0 = 16'h1234; dp0_in = 4'b0000;
    tick();
    load0 = 1'b0; en0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({an0, seg0, fd0} !== {ea[i], es[i], ef[i]}) begin
        errors++;
        $display("FAIL g0_step%0d: an=%b seg=%b fd=%b want %b/%b/%b", i, an0, seg0, fd0, ea[i], es[i], ef[i]);
      end
    end
    load0 = 1'b1; value0 = 16'h9999;
    tick();
    load0 = 1'b0;
    checks++;
    if ({an0, idx0} !== {4'b1011, 3'd2}) begin
      errors++;
      $display("FAIL g0_digit2: an=%b idx=%0d want 1011/2", an0, idx0);
    end
    r0 = 1'b1; load0 = 1'b1; value0 = 16'h7777;
    tick();
    r0 = 1'b0; load0 = 1'b0;
    checks++;
    if ({an0, seg0, dp0, idx0, fd0} !== {4'b1111, SOFF, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL g0_rst: an=%b seg=%b dp=%b idx=%0d fd=%b", an0, seg0, dp0, idx0, fd0);
    end
    tick();
    checks++;
    if ({an0, seg0} !== {4'b1110, S0}) begin
      errors++;
      $display("FAIL g0_pend_cleared: an=%b seg=%b want 1110/%b", an0, seg0, S0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timing();
    test_tearing();
    test_lz_blank();
    test_en_drop();
    test_guard0_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
